// File: rtl/softmax_input_loader_if.sv
// Scalar element stream feeding softmax_input_loader (valid/ready with end-of-vector marker).
interface softmax_input_loader_if #(
  parameter int DATAWIDTH = 16
);
  logic [DATAWIDTH-1:0] s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/softmax_input_loader.sv
// Packs a scalar stream into NUM-lane buffer lines, then kicks the softmax engine.
// Optional WAIT watchdog enabled by defining SOFTMAX_LOADER_TIMEOUT_EN.
module softmax_input_loader #(
  parameter int                   DATAWIDTH = 16,
  parameter int                   NUM       = 4,
  parameter int                   ADDRSIZE  = 8,
  parameter int                   MAX_LINES = 64,
  parameter logic [DATAWIDTH-1:0] PAD_VALUE = 16'h0000,
  parameter int                   TIMEOUT   = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  softmax_input_loader_if.slave     s,
  input  logic [ADDRSIZE-1:0]       base_addr,
  output logic                      wr_en,
  output logic [ADDRSIZE-1:0]       wr_addr,
  output logic [DATAWIDTH*NUM-1:0]  wr_data,
  output logic [ADDRSIZE-1:0]       sm_start_addr,
  output logic [ADDRSIZE-1:0]       sm_end_addr,
  output logic                      sm_init,
  output logic                      sm_start,
  input  logic                      sm_done,
  output logic                      busy,
  output logic                      vec_done,
  output logic                      err_overflow
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  localparam int LANE_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int LINE_W = $clog2(MAX_LINES) + 1;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("softmax_input_loader: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, FILL, FLUSH, INIT, START, WAIT} state_t;

  state_t                          state;
  logic [LANE_W-1:0]               lane_cnt;
  logic [LINE_W-1:0]               line_cnt;
  logic [ADDRSIZE-1:0]             ptr;
  logic [NUM-1:0][DATAWIDTH-1:0]   line;
  logic [NUM-1:0][DATAWIDTH-1:0]   filled;
  logic [DATAWIDTH-1:0]            beat;
  logic                            is_idle, accept, complete;
  logic [LANE_W-1:0]               lane;
  logic [LINE_W-1:0]               cnt_cur;
  logic [ADDRSIZE-1:0]             ptr_cur;

  assign beat      = s.s_data;
  assign is_idle   = (state == IDLE);
  assign s.s_ready = is_idle || (state == FILL);
  assign accept    = s.s_valid && s.s_ready;
  assign busy      = !is_idle;

  // The first beat of a vector behaves as if counters were already cleared.
  assign lane     = is_idle ? '0 : lane_cnt;
  assign cnt_cur  = is_idle ? '0 : line_cnt;
  assign ptr_cur  = is_idle ? base_addr : ptr;
  assign complete = s.s_last || (lane == LANE_W'(NUM - 1));

  always_comb begin
    filled       = is_idle ? {NUM{PAD_VALUE}} : line;
    filled[lane] = beat;
  end

`ifdef SOFTMAX_LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      lane_cnt      <= '0;
      line_cnt      <= '0;
      ptr           <= '0;
      line          <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      sm_start_addr <= '0;
      sm_end_addr   <= '0;
      sm_init       <= 1'b0;
      sm_start      <= 1'b0;
      vec_done      <= 1'b0;
      err_overflow  <= 1'b0;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
      timeout       <= 1'b0;
      wd            <= '0;
`endif
    end else begin
      wr_en    <= 1'b0;
      sm_init  <= 1'b0;
      sm_start <= 1'b0;
      vec_done <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            if (is_idle) begin
              sm_start_addr <= base_addr;
              err_overflow  <= 1'b0;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
              timeout       <= 1'b0;
`endif
            end
            if (complete) begin
              lane_cnt <= '0;
              line     <= {NUM{PAD_VALUE}};
              // Lines past MAX_LINES are dropped; beats keep draining until s_last.
              if (cnt_cur == LINE_W'(MAX_LINES)) begin
                err_overflow <= 1'b1;
                ptr          <= ptr_cur;
                line_cnt     <= cnt_cur;
              end else begin
                wr_en    <= 1'b1;
                wr_addr  <= ptr_cur;
                wr_data  <= filled;
                ptr      <= ptr_cur + ADDRSIZE'(1);
                line_cnt <= cnt_cur + LINE_W'(1);
              end
            end else begin
              lane_cnt <= lane + LANE_W'(1);
              line     <= filled;
              ptr      <= ptr_cur;
              line_cnt <= cnt_cur;
            end
            state <= s.s_last ? FLUSH : FILL;
          end
        end
        FLUSH: begin
          sm_init     <= 1'b1;
          sm_end_addr <= sm_start_addr + ADDRSIZE'(line_cnt);
          state       <= INIT;
        end
        INIT: begin
          sm_start <= 1'b1;
          state    <= START;
        end
        START: begin
          state <= WAIT;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        WAIT: begin
          if (sm_done) begin
            vec_done <= 1'b1;
            state    <= IDLE;
          end
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wd <= wd + WD_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/softmax_input_loader.md
Name: softmax_input_loader

Overview:
- Upstream feeder for the softmax engine.
- Accepts a stream of scalar DATAWIDTH elements with valid/ready.
- Packs them into NUM-lane lines, writes the lines to the on-chip buffer from base_addr upward, then pulses init and start to softmax.
- Holds off new input until softmax asserts done; one vector in flight.

Parameters:
DATAWIDTH, 16, element width in bits
NUM, 4, lanes per memory line; must match softmax
ADDRSIZE, 8, buffer address width
MAX_LINES, 64, maximum lines per vector
PAD_VALUE, 16'h0000, DATAWIDTH-bit fill for unused lanes of the final partial line
TIMEOUT, 4096, watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low; asserted when 0
s_data  in  DATAWIDTH  input element
s_valid  in  1  s_data valid
s_last  in  1  marks the last element of a vector
s_ready  out  1  loader accepts a beat
base_addr  in  ADDRSIZE  first buffer line; sampled on the first beat of a vector
wr_en  out  1  buffer write strobe
wr_addr  out  ADDRSIZE  buffer write line address
wr_data  out  DATAWIDTH*NUM  packed line; lane k = bits [k*DATAWIDTH +: DATAWIDTH]
sm_start_addr  out  ADDRSIZE  to softmax start_addr
sm_end_addr  out  ADDRSIZE  to softmax end_addr; exclusive
sm_init  out  1  one-cycle pulse to softmax init
sm_start  out  1  one-cycle pulse to softmax start
sm_done  in  1  softmax done
busy  out  1  high in every state except IDLE
vec_done  out  1  one-cycle pulse when sm_done is seen
err_overflow  out  1  sticky overflow flag; cleared on the first beat of the next vector

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, all outputs 0.
  - Lane counter, line counter and partial line are cleared; the partial line is discarded.
  - Applies mid-operation; any pending softmax run is abandoned.
- Beat acceptance: a beat is accepted on an edge where s_valid&&s_ready. s_ready is combinational = (state==IDLE || state==FILL).
- IDLE:
  - On an accepted beat: latch wr pointer=base_addr and sm_start_addr=base_addr.
  - Clear line_cnt and err_overflow; store the beat in lane 0.
  - Go to FILL, or to FLUSH if s_last is set.
- FILL:
  - Each accepted beat goes to lane lane_cnt.
  - When lane NUM-1 is filled, or s_last is set, the line is emitted.
  - On s_last go to FLUSH.
- Line emit:
  - Registered: wr_en=1 for exactly the cycle after the completing beat's edge.
  - wr_addr=pointer; then pointer+1 and line_cnt+1.
  - Unfilled lanes = PAD_VALUE.
  - lane_cnt returns to 0.
- Overflow:
  - If line_cnt==MAX_LINES at emit time, the line is not written (wr_en stays 0) and err_overflow=1.
  - Beats continue to be accepted and dropped until s_last.
- FLUSH: one cycle; the final wr_en is visible here. Go to INIT.
- INIT:
  - sm_init=1 for one cycle.
  - sm_end_addr=base+line_cnt, modulo 2^ADDRSIZE.
  - Go to START.
- START: sm_start=1 for one cycle. Go to WAIT.
- sm_start_addr and sm_end_addr are held stable from INIT until the next vector's first beat.
- Latency: last beat accepted at edge E0 → wr_en high in cycle E0+1 → sm_init in E0+2 → sm_start in E0+3.
- WAIT:
  - s_ready=0.
  - On sm_done==1: vec_done=1 for one cycle, then go to IDLE.
  - sm_done is ignored in every other state.
- Vector of exactly NUM*k elements: no padded line. Length 1: one line with lanes 1..NUM-1 padded.
- Counter widths: line_cnt is log2(MAX_LINES)+1 bits. lane_cnt is log2(NUM) bits and wraps naturally when NUM is a power of 2; otherwise it is explicitly reset at NUM-1.

Optional Feature:
- Macro: SOFTMAX_LOADER_TIMEOUT_EN.
- When defined:
  - A watchdog counts cycles spent in WAIT.
  - On reaching TIMEOUT without sm_done, output timeout (1 bit, sticky until the next vector's first beat) is set and state returns to IDLE.
  - vec_done is not pulsed on a timeout.
- When undefined: no timeout port, no counter; WAIT lasts until sm_done.

Test Plan:
1. NUM=4, base_addr=8, stream 1..8 with s_last on 8 → writes at addr 8 {4,3,2,1} and addr 9 {8,7,6,5}; sm_start_addr=8, sm_end_addr=10; sm_init two cycles after the last accept, sm_start one cycle later.
2. Stream 1..5 with s_last on 5 → line 2 = {PAD,PAD,PAD,5} at base+1; sm_end_addr=base+2; single element vector writes {PAD,PAD,PAD,x}.
3. s_valid held high during WAIT → s_ready=0, no beats accepted; drive sm_done → vec_done pulse next cycle, s_ready=1 again.
4. MAX_LINES=2, stream 12 elements → only 2 writes, err_overflow=1, all 12 beats accepted, sm_end_addr=base+2; next vector's first beat clears err_overflow.
5. reset=0 asserted mid-FILL after 3 beats → next cycle all outputs 0, state IDLE; a new vector starts cleanly with lane 0 and the re-sampled base_addr.
6. With SOFTMAX_LOADER_TIMEOUT_EN and TIMEOUT=16, never drive sm_done → timeout=1 after 16 WAIT cycles, state returns to IDLE, no vec_done.
